// File: rtl/router_psum_out_pkg.sv
// router_psum_out_pkg: shared job geometry, GLB base addresses and FSM encoding
package router_psum_out_pkg;
  localparam int DATA_BITWIDTH = 16;
  localparam int ADDR_BITWIDTH_GLB = 10;
  localparam int KERNEL_SIZE = 3;
  localparam int ACT_SIZE = 5;
  localparam int NUM_PSUM = (ACT_SIZE - KERNEL_SIZE + 1) * (ACT_SIZE - KERNEL_SIZE + 1);
  localparam int FIFO_DEPTH = 4;
  localparam int A_READ_ADDR = 0;
  localparam int A_LOAD_ADDR = 0;
  localparam int P_WRITE_ADDR = 500;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/router_psum_out_if.sv
// router_psum_out_if: PE psum handshake plus GLB write port
// slave = router side (takes psums, drives GLB writes); master = PE/GLB environment side
interface router_psum_out_if #(
  parameter int DATA_BITWIDTH = router_psum_out_pkg::DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = router_psum_out_pkg::ADDR_BITWIDTH_GLB
);
  logic [DATA_BITWIDTH-1:0] psum_data_i;
  logic psum_enable_i;
  logic psum_ready_o;
  logic glb_busy_i;
  logic [ADDR_BITWIDTH_GLB-1:0] psum_addr_write;
  logic [DATA_BITWIDTH-1:0] psum_data_write;
  logic psum_write_en;
  modport slave (
    input psum_data_i, psum_enable_i, glb_busy_i,
    output psum_ready_o, psum_addr_write, psum_data_write, psum_write_en
  );
  modport master (
    output psum_data_i, psum_enable_i, glb_busy_i,
    input psum_ready_o, psum_addr_write, psum_data_write, psum_write_en
  );
endinterface

// File: rtl/router_psum_out_sync_fifo.sv
// sync_fifo: small synchronous FIFO with registered head; push+pop together is legal when not full
// ports: clk, rst, clr (flush), push/din, pop, full, empty, head
module sync_fifo #(
  parameter int DATA_BITWIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [DATA_BITWIDTH-1:0] din,
  output logic full,
  output logic empty,
  output logic [DATA_BITWIDTH-1:0] head
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/router_psum_out.sv
// router_psum_out: buffers PE partial sums and writes them in order to the GLB from a base address
// ports: clk, reset (sync, active-high), start, done_o (one-cycle pulse), bus (psum handshake + GLB write)
module router_psum_out #(
  parameter int DATA_BITWIDTH = router_psum_out_pkg::DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH_GLB = router_psum_out_pkg::ADDR_BITWIDTH_GLB,
  parameter int NUM_PSUM = router_psum_out_pkg::NUM_PSUM,
  parameter int FIFO_DEPTH = router_psum_out_pkg::FIFO_DEPTH,
  parameter int P_WRITE_ADDR = router_psum_out_pkg::P_WRITE_ADDR
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done_o,
  router_psum_out_if.slave bus
);
  import router_psum_out_pkg::*;
  localparam int CW = $clog2(NUM_PSUM + 1);
  state_t state, state_nx;
  logic [CW-1:0] accept_cnt, write_cnt;
  logic [DATA_BITWIDTH-1:0] head;
  logic full, empty, push, pop, clr;
  assign bus.psum_ready_o = state == ACTIVE && !full && accept_cnt < CW'(NUM_PSUM);
  assign push = bus.psum_enable_i && bus.psum_ready_o;
  assign pop = (state == ACTIVE || state == DRAIN) && !empty && !bus.glb_busy_i;
  assign clr = state == IDLE && start;
  assign done_o = state == DONE;
  sync_fifo #(.DATA_BITWIDTH(DATA_BITWIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(reset), .clr(clr), .push(push), .pop(pop), .din(bus.psum_data_i),
    .full(full), .empty(empty), .head(head)
  );
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE   ? (start ? ACTIVE : IDLE) :
               state == ACTIVE ? (push && accept_cnt == CW'(NUM_PSUM - 1) ? DRAIN : ACTIVE) :
               state == DRAIN  ? (write_cnt == CW'(NUM_PSUM) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      accept_cnt <= '0;
      write_cnt <= '0;
      bus.psum_write_en <= 1'b0;
      bus.psum_data_write <= '0;
      bus.psum_addr_write <= '0;
    end else begin
      state <= state_nx;
      bus.psum_write_en <= pop;
      accept_cnt <= clr ? '0 : accept_cnt + CW'(push);
      write_cnt <= clr ? '0 : write_cnt + CW'(pop && write_cnt < CW'(NUM_PSUM));
      if (pop) begin
        bus.psum_data_write <= head;
        bus.psum_addr_write <= ADDR_BITWIDTH_GLB'(P_WRITE_ADDR + int'(write_cnt));
      end
    end
  end
endmodule

// File: tb/tb_router_psum_out.sv
// tb_router_psum_out: vector table plus directed sequences, with a scoreboard over GLB writes
module tb_router_psum_out;
  import router_psum_out_pkg::*;
  typedef struct {logic st; logic en; logic [15:0] d; logic bsy; logic rdy; logic wen; logic dn;} vec_t;
  typedef struct {logic [15:0] d; int k;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic en = 1'b0;
  logic busy = 1'b0;
  logic [15:0] data = '0;
  logic done_b, done_w;
  int checks = 0;
  int errors = 0;
  int acc = 0;
  int writes = 0;
  int dones_b = 0;
  int dones_w = 0;
  exp_t q[$];
  exp_t e_m;
  vec_t tv[14];
  router_psum_out_if ib();
  router_psum_out_if iw();
  assign ib.psum_data_i = data;
  assign ib.psum_enable_i = en;
  assign ib.glb_busy_i = busy;
  assign iw.psum_data_i = data;
  assign iw.psum_enable_i = en;
  assign iw.glb_busy_i = busy;
  router_psum_out dut_b (.clk(clk), .reset(reset), .start(start), .done_o(done_b), .bus(ib));
  router_psum_out #(.P_WRITE_ADDR(1020)) dut_w (.clk(clk), .reset(reset), .start(start), .done_o(done_w), .bus(iw));
  always #5 clk = ~clk;
  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic cyc(input logic s, input logic e, input logic [15:0] d, input logic b);
    @(negedge clk);
    start = s;
    en = e;
    data = d;
    busy = b;
    #1;
  endtask
  task automatic accept();
    if (en && ib.psum_ready_o) begin
      q.push_back('{data, acc});
      acc++;
    end
  endtask
  task automatic new_job();
    acc = 0;
    writes = 0;
    dones_b = 0;
    dones_w = 0;
    q.delete();
  endtask
  task automatic finish_job(input string n);
    for (int i = 0; i < 60 && dones_b == 0; i++) cyc(1'b0, 1'b0, 16'd0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 16'd0, 1'b0);
    chk({n, "_accepts"}, acc, NUM_PSUM);
    chk({n, "_writes"}, writes, NUM_PSUM);
    chk({n, "_done_b"}, dones_b, 1);
    chk({n, "_done_w"}, dones_w, 1);
    chk({n, "_queue_left"}, q.size(), 0);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (ib.psum_write_en || iw.psum_write_en) begin
        chk("wen_b", ib.psum_write_en, 1);
        chk("wen_w", iw.psum_write_en, 1);
        if (q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e_m = q.pop_front();
          writes++;
          chk("wr_data", ib.psum_data_write, e_m.d);
          chk("wr_addr", ib.psum_addr_write, 500 + e_m.k);
          chk("wrap_data", iw.psum_data_write, e_m.d);
          chk("wrap_addr", iw.psum_addr_write, (1020 + e_m.k) % 1024);
        end
      end
      if (done_b) dones_b++;
      if (done_w) dones_w++;
    end
  end
  initial begin
    tv[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 1; i <= 9; i++) tv[i] = '{(i == 5), 1'b1, 16'(i), 1'b0, 1'b1, (i >= 3), 1'b0};
    tv[10] = '{1'b0, 1'b1, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[11] = '{1'b0, 1'b1, 16'd10, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[12] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (2) cyc(1'b0, 1'b0, 16'd0, 1'b0);
    chk("rst_ready", ib.psum_ready_o, 0);
    chk("rst_wen", ib.psum_write_en, 0);
    chk("rst_addr", ib.psum_addr_write, 0);
    chk("rst_data", ib.psum_data_write, 0);
    chk("rst_done", done_b, 0);
    chk("rst_wrap_addr", iw.psum_addr_write, 0);
    reset = 1'b0;
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    new_job();
    for (int i = 0; i < 14; i++) begin
      cyc(tv[i].st, tv[i].en, tv[i].d, tv[i].bsy);
      chk($sformatf("vec%0d_ready", i), ib.psum_ready_o, tv[i].rdy);
      chk($sformatf("vec%0d_wen", i), ib.psum_write_en, tv[i].wen);
      chk($sformatf("vec%0d_done", i), done_b, tv[i].dn);
      if (tv[i].en && tv[i].rdy) begin
        q.push_back('{tv[i].d, acc});
        acc++;
      end
    end
    finish_job("basic");
    new_job();
    cyc(1'b1, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 16'(100 + acc), 1'b1);
      chk($sformatf("bp%0d_ready", i), ib.psum_ready_o, i < 4);
      chk($sformatf("bp%0d_no_write", i), ib.psum_write_en, 0);
      accept();
    end
    chk("bp_held_accepts", acc, 4);
    for (int i = 0; i < 60 && acc < NUM_PSUM; i++) begin
      cyc(1'b0, 1'b1, 16'(100 + acc), 1'b0);
      accept();
    end
    finish_job("bp");
    new_job();
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 16'(300 + acc), 1'b0);
      accept();
    end
    @(negedge clk);
    reset = 1'b1;
    en = 1'b0;
    #1;
    cyc(1'b0, 1'b0, 16'd0, 1'b0);
    chk("midrst_ready", ib.psum_ready_o, 0);
    chk("midrst_wen", ib.psum_write_en, 0);
    chk("midrst_addr", ib.psum_addr_write, 0);
    chk("midrst_data", ib.psum_data_write, 0);
    chk("midrst_done", done_b, 0);
    q.delete();
    reset = 1'b0;
    repeat (6) cyc(1'b0, 1'b1, 16'd999, 1'b0);
    chk("midrst_idle_ready", ib.psum_ready_o, 0);
    chk("midrst_no_done", dones_b, 0);
    new_job();
    cyc(1'b1, 1'b0, 16'd0, 1'b0);
    for (int i = 0; i < 400 && acc < NUM_PSUM; i++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)), 16'(400 + acc), 1'($urandom_range(0, 2) == 0));
      accept();
    end
    finish_job("gap");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
